// File: rtl/qspi_read_scheduler_pkg.sv
// Shared types and constants for the QSPI read scheduler: FSM state encoding,
// requester port identifiers and default field widths.
package qspi_read_scheduler_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 24;
  localparam int unsigned DEFAULT_LEN_W  = 8;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [2:0] {
    StGuard,
    StIdle,
    StIssue,
    StWait,
    StDeliver
  } state_e;

endpackage

// File: rtl/qspi_read_scheduler_if.sv
// Requester-side burst port: descriptor request/grant plus a valid/ready byte
// stream and a done pulse on the last accepted byte.
interface qspi_read_scheduler_if
  import qspi_read_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned LEN_W  = DEFAULT_LEN_W
) ();

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic              gnt;
  logic [7:0]        data;
  logic              valid;
  logic              dready;
  logic              done;

  modport master (
    output req, addr, len, dready,
    input  gnt, data, valid, done
  );

  modport slave (
    input  req, addr, len, dready,
    output gnt, data, valid, done
  );

endinterface

// File: rtl/qspi_read_scheduler_rr_arb2.sv
// Two-way round-robin grant; priority moves to the other port when the owner's
// burst completes, so the arbiter only changes preference at burst boundaries.
module qspi_read_scheduler_rr_arb2
  import qspi_read_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  input  logic       i_done,
  input  logic       i_owner,
  output logic [1:0] o_gnt
);

  logic r_prio;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= PORT_A;
    end else if (i_done) begin
      r_prio <= ~i_owner;
    end
  end

  // Bit index of o_gnt is the port id.
  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      unique case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = (r_prio == PORT_A) ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/qspi_read_scheduler.sv
// Shares one QSPI byte reader between two burst requesters; one flash read per
// byte, single-byte holding register, round-robin choice at burst boundaries.
module qspi_read_scheduler
  import qspi_read_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
  parameter int unsigned LEN_W     = DEFAULT_LEN_W,
  parameter int unsigned RST_GUARD = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  qspi_read_scheduler_if.slave  io_a,
  qspi_read_scheduler_if.slave  io_b,
  output logic                  o_rd_read,
  output logic [ADDR_W-1:0]     o_rd_addr,
  input  logic                  i_rd_ready,
  input  logic [7:0]            i_rd_data
);

  localparam int unsigned GuardW = $clog2(RST_GUARD + 2);

  state_e              r_state, w_state_next;
  logic [GuardW-1:0]   r_guard, w_guard_next;
  logic [ADDR_W-1:0]   r_cur_addr, w_addr_next;
  logic [LEN_W-1:0]    r_remaining, w_rem_next;
  logic                r_owner, w_owner_next;
  logic [7:0]          r_hold, w_hold_next;

  logic [1:0]          w_gnt;
  logic                w_accept;
  logic                w_done;
  logic                w_rd_read;
  logic                w_valid_a;
  logic                w_valid_b;

  qspi_read_scheduler_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_en    (r_state == StIdle),
    .i_req   ({io_b.req, io_a.req}),
    .i_done  (w_done),
    .i_owner (r_owner),
    .o_gnt   (w_gnt)
  );

  assign w_accept = (r_state == StDeliver) &&
                    ((r_owner == PORT_B) ? io_b.dready : io_a.dready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StGuard;
      r_guard     <= GuardW'(RST_GUARD);
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_owner     <= PORT_A;
      r_hold      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_guard     <= w_guard_next;
      r_cur_addr  <= w_addr_next;
      r_remaining <= w_rem_next;
      r_owner     <= w_owner_next;
      r_hold      <= w_hold_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_guard_next = r_guard;
    w_addr_next  = r_cur_addr;
    w_rem_next   = r_remaining;
    w_owner_next = r_owner;
    w_hold_next  = r_hold;
    w_rd_read    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      // The reader has no reset; wait out any transaction still in flight.
      StGuard: begin
        if (r_guard <= GuardW'(1)) begin
          w_guard_next = '0;
          w_state_next = StIdle;
        end else begin
          w_guard_next = r_guard - GuardW'(1);
        end
      end
      StIdle: begin
        if (w_gnt != 2'b00) begin
          w_owner_next = w_gnt[PORT_B] ? PORT_B : PORT_A;
          w_addr_next  = w_gnt[PORT_B] ? io_b.addr : io_a.addr;
          w_rem_next   = w_gnt[PORT_B] ? io_b.len : io_a.len;
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        w_rd_read    = 1'b1;
        w_state_next = StWait;
      end
      StWait: begin
        if (i_rd_ready) begin
          w_hold_next  = i_rd_data;
          w_state_next = StDeliver;
        end
      end
      StDeliver: begin
        if (w_accept) begin
          if (r_remaining == '0) begin
            w_done       = 1'b1;
            w_state_next = StIdle;
          end else begin
            w_rem_next   = r_remaining - LEN_W'(1);
            w_addr_next  = r_cur_addr + ADDR_W'(1);
            w_state_next = StIssue;
          end
        end
      end
      default: w_state_next = StGuard;
    endcase
  end

  assign w_valid_a = (r_state == StDeliver) && (r_owner == PORT_A);
  assign w_valid_b = (r_state == StDeliver) && (r_owner == PORT_B);

  assign io_a.gnt   = w_gnt[PORT_A];
  assign io_a.valid = w_valid_a;
  assign io_a.data  = w_valid_a ? r_hold : 8'h00;
  assign io_a.done  = w_done && (r_owner == PORT_A);

  assign io_b.gnt   = w_gnt[PORT_B];
  assign io_b.valid = w_valid_b;
  assign io_b.data  = w_valid_b ? r_hold : 8'h00;
  assign io_b.done  = w_done && (r_owner == PORT_B);

  assign o_rd_read = w_rd_read;
  assign o_rd_addr = r_cur_addr;

endmodule

// File: tb/tb_qspi_read_scheduler.sv
// Bench for qspi_read_scheduler: flash reader model with variable latency and a
// transaction-level scoreboard checking grants, reads, bytes and done pulses.
module tb_qspi_read_scheduler;

  localparam int G = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_read;
  logic [23:0] rd_addr;
  logic        rd_ready = 1'b0;
  logic [7:0]  rd_data = 8'h00;

  always #5 clk = ~clk;

  qspi_read_scheduler_if #(.ADDR_W(24), .LEN_W(8)) a_bus ();
  qspi_read_scheduler_if #(.ADDR_W(24), .LEN_W(8)) b_bus ();

  qspi_read_scheduler #(
    .ADDR_W    (24),
    .LEN_W     (8),
    .RST_GUARD (G)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .io_a       (a_bus),
    .io_b       (b_bus),
    .o_rd_read  (rd_read),
    .o_rd_addr  (rd_addr),
    .i_rd_ready (rd_ready),
    .i_rd_data  (rd_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Flash contents as a fixed function of the address.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return {a[3:0], a[7:4]} ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  // Scoreboard state: one burst at a time, one byte in flight at a time.
  bit          m_busy, m_owner, m_pending, m_waiting, m_issue_due;
  bit          m_last = 1'b1;
  logic [23:0] m_addr;
  int          m_left;
  int          cyc = -1;
  int          first_rd_cyc = -1;
  int          last_gnt_cyc = -1;
  int          rd_count = 0;
  bit          grant_log[$];
  logic [23:0] rd_log[$];

  bit          rdr_busy = 1'b0;
  int          rdr_cnt;
  logic [23:0] rdr_addr;
  int          rd_lat_fix = 0;
  int          dr_mode[2] = '{1, 1};

  initial begin
    forever begin
      @(negedge clk);
      monitor_step();
    end
  end

  task automatic monitor_step();
    logic [1:0] req;
    logic [1:0] gnt_exp;
    bit         acc;
    if (rst) begin
      m_busy = 0; m_pending = 0; m_waiting = 0; m_issue_due = 0; m_last = 1'b1;
      cyc = -1; first_rd_cyc = -1;
    end else begin
      cyc++;
      req = {b_bus.req, a_bus.req};
      gnt_exp = 2'b00;
      if (!m_busy && cyc >= G) begin
        if (req == 2'b11) gnt_exp = m_last ? 2'b01 : 2'b10;
        else gnt_exp = req;
      end
      check("gnt_a", 32'(a_bus.gnt), 32'(gnt_exp[0]));
      check("gnt_b", 32'(b_bus.gnt), 32'(gnt_exp[1]));
      check("rd_read", 32'(rd_read), 32'(m_issue_due));
      if (rd_read) begin
        check("rd_addr", 32'(rd_addr), 32'(m_addr));
        rd_count++;
        rd_log.push_back(rd_addr);
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      check("valid_a", 32'(a_bus.valid), 32'(m_pending && !m_owner));
      check("valid_b", 32'(b_bus.valid), 32'(m_pending && m_owner));
      acc = m_pending && (m_owner ? b_bus.dready : a_bus.dready);
      check("done_a", 32'(a_bus.done), 32'(acc && !m_owner && m_left == 1));
      check("done_b", 32'(b_bus.done), 32'(acc && m_owner && m_left == 1));
      if (m_pending) begin
        if (m_owner) check("data_b", 32'(b_bus.data), 32'(mem_byte(m_addr)));
        else         check("data_a", 32'(a_bus.data), 32'(mem_byte(m_addr)));
      end
      if (m_issue_due) begin
        m_issue_due = 0;
        m_waiting   = 1;
      end
      if (acc) begin
        m_pending = 0;
        if (m_left == 1) begin
          m_busy = 0;
          m_last = m_owner;
        end else begin
          m_left--;
          m_addr++;
          m_issue_due = 1;
        end
      end
      if (gnt_exp != 2'b00) begin
        m_busy       = 1;
        m_owner      = gnt_exp[1];
        m_addr       = m_owner ? b_bus.addr : a_bus.addr;
        m_left       = int'(m_owner ? b_bus.len : a_bus.len) + 1;
        m_issue_due  = 1;
        last_gnt_cyc = cyc;
        grant_log.push_back(m_owner);
      end
    end
    // Reader model keeps running through reset, like the real reader.
    rd_ready = 1'b0;
    if (rdr_busy) begin
      rdr_cnt--;
      if (rdr_cnt == 0) begin
        rdr_busy = 0;
        rd_ready = 1'b1;
        rd_data  = mem_byte(rdr_addr);
        if (!rst && m_waiting) check("rd_addr_hold", 32'(rd_addr), 32'(rdr_addr));
      end
    end
    if (!rst && rd_read) begin
      check("rd_overlap", 32'(rdr_busy), 32'd0);
      rdr_busy = 1;
      rdr_addr = rd_addr;
      rdr_cnt  = (rd_lat_fix != 0) ? rd_lat_fix : int'($urandom_range(1, 8));
    end
    if (!rst && m_waiting && rd_ready) begin
      m_waiting = 0;
      m_pending = 1;
    end
  endtask

  function automatic logic pick(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  initial begin
    a_bus.dready = 1'b0;
    b_bus.dready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      a_bus.dready = pick(dr_mode[0]);
      b_bus.dready = pick(dr_mode[1]);
    end
  end

  task automatic post(input bit port, input logic [23:0] addr, input logic [7:0] len);
    int t = 0;
    @(posedge clk);
    #1;
    if (port) begin b_bus.req = 1'b1; b_bus.addr = addr; b_bus.len = len; end
    else      begin a_bus.req = 1'b1; a_bus.addr = addr; a_bus.len = len; end
    do begin
      @(negedge clk);
      t++;
    end while (!(port ? b_bus.gnt : a_bus.gnt) && t < 3000);
    if (port) check("gnt_wait_b", 32'(t < 3000), 32'd1);
    else      check("gnt_wait_a", 32'(t < 3000), 32'd1);
    @(posedge clk);
    #1;
    // Descriptor inputs are don't-care outside the grant cycle.
    if (port) begin b_bus.req = 1'b0; b_bus.addr = 24'($urandom); b_bus.len = 8'($urandom); end
    else      begin a_bus.req = 1'b0; a_bus.addr = 24'($urandom); a_bus.len = 8'($urandom); end
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((m_busy || a_bus.req || b_bus.req) && t < 5000);
    check("idle_timeout", 32'(t < 5000), 32'd1);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int rc;
    int n;
    a_bus.req = 1'b0; a_bus.addr = '0; a_bus.len = '0;
    b_bus.req = 1'b0; b_bus.addr = '0; b_bus.len = '0;
    repeat (3) @(posedge clk);

    // Request waiting at reset release: first read lands right after the guard.
    fork
      post(1'b0, 24'h400000, 8'd3);
      begin @(posedge clk); #1 rst = 1'b0; end
    join
    wait_idle();
    check("first_rd_cycle", 32'(first_rd_cyc), 32'(G + 1));

    rd_log.delete();
    post(1'b0, 24'hFFFFFF, 8'd1);
    wait_idle();
    check("wrap_addr0", 32'(rd_log[0]), 32'hFFFFFF);
    check("wrap_addr1", 32'(rd_log[1]), 32'h000000);

    dr_mode[1] = 0;
    post(1'b1, 24'h123456, 8'd1);
    n = 0;
    while (!b_bus.valid && n < 100) begin @(negedge clk); n++; end
    check("stall_valid", 32'(b_bus.valid), 32'd1);
    rc = rd_count;
    repeat (50) @(negedge clk);
    check("stall_no_rd", 32'(rd_count - rc), 32'd0);
    dr_mode[1] = 1;
    wait_idle();

    grant_log.delete();
    fork
      post(1'b0, 24'h00A000, 8'd5);
      begin
        repeat (5) @(posedge clk);
        #1 b_bus.req = 1'b1;
        repeat (2) @(posedge clk);
        #1 b_bus.req = 1'b0;
      end
    join
    wait_idle();
    repeat (20) @(negedge clk);
    check("withdraw_grants", 32'(grant_log.size()), 32'd1);

    // Reset while the reader is busy; its late completion must be swallowed.
    rd_lat_fix = 10;
    rc = rd_count;
    post(1'b0, 24'h0BEEF0, 8'd2);
    do_reset(1);
    rd_lat_fix = 0;
    check("rd_before_rst", 32'(rd_count - rc), 32'd1);
    post(1'b0, 24'h055AA0, 8'd2);
    check("guard_gnt", 32'(last_gnt_cyc), 32'(G));
    wait_idle();

    do_reset(2);
    grant_log.delete();
    fork
      post(1'b0, 24'h111111, 8'd0);
      post(1'b1, 24'h222222, 8'd0);
    join
    wait_idle();
    check("rr_first_a", 32'(grant_log[0]), 32'd0);
    check("rr_then_b", 32'(grant_log[1]), 32'd1);
    post(1'b0, 24'h333333, 8'd0);
    wait_idle();
    grant_log.delete();
    fork
      post(1'b0, 24'h444444, 8'd0);
      post(1'b1, 24'h555555, 8'd0);
    join
    wait_idle();
    check("rr_first_b", 32'(grant_log[0]), 32'd1);
    check("rr_then_a", 32'(grant_log[1]), 32'd0);

    for (int i = 0; i < 30; i++) begin
      dr_mode[0] = int'($urandom_range(1, 2));
      dr_mode[1] = int'($urandom_range(1, 2));
      case ($urandom_range(0, 2))
        0: post(1'b0, 24'($urandom), 8'($urandom_range(0, 15)));
        1: post(1'b1, 24'($urandom), 8'($urandom_range(0, 15)));
        default: begin
          fork
            post(1'b0, 24'($urandom), 8'($urandom_range(0, 15)));
            begin
              repeat ($urandom_range(0, 6)) @(posedge clk);
              post(1'b1, 24'($urandom), 8'($urandom_range(0, 15)));
            end
          join
        end
      endcase
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #800000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
